// File: rtl/sram_bridge_pkg.sv
// Shared types for the SRAM bridge: the word request and the macro pin bundle
// for the two 512x8 banks that together form one 512x16 memory.
package sram_bridge_pkg;

    localparam int BANKS      = 2;
    localparam int BANK_W     = 8;
    localparam int SRAM_DEPTH = 512;
    localparam int SRAM_AW    = $clog2(SRAM_DEPTH);
    localparam int WORD_W     = BANKS * BANK_W;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [WORD_W-1:0]  wdata;
        logic [BANKS-1:0]   be;
    } sram_req_t;

    typedef struct packed {
        logic [BANKS-1:0]   cen;
        logic [BANKS-1:0]   gwen;
        logic [WORD_W-1:0]  wen;
        logic [SRAM_AW-1:0] a;
        logic [WORD_W-1:0]  d;
    } sram_pins_t;

    // All macro controls are active-low, so idle means every enable high.
    function automatic sram_pins_t idle_pins();
        sram_pins_t p;
        p.cen  = '1;
        p.gwen = '1;
        p.wen  = '1;
        p.a    = '0;
        p.d    = '0;
        return p;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH so
// non-power-of-two depths work too.
module sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_bridge.sv
// Valid/ready front end for the two 512x8 SRAM macros: drives their active-low
// pins in the handshake cycle and queues read data in a small response FIFO.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W    = SRAM_AW,
    parameter int DATA_W    = WORD_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        sram_cen,
    output logic [1:0]        sram_gwen,
    output logic [DATA_W-1:0] sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    sram_req_t        req;
    sram_pins_t       pins;
    logic             fire;
    logic             pop;
    logic             rd_inflight;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    int               occupancy;

    assign req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable until then. req_ready reserves a FIFO
    // slot for every read in flight, so it looks through a same-cycle pop.
    always_comb begin
        occupancy = int'(fifo_count) + int'(rd_inflight) - int'(pop);
        req_ready = rst_n && (occupancy < RSP_DEPTH);
    end

    assign fire      = req_valid && req_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) rd_inflight <= 1'b0;
        else        rd_inflight <= fire && !req.we;
    end

    // A write with no byte enables is consumed but leaves the macros idle.
    always_comb begin
        pins = idle_pins();
        if (fire) begin
            if (!req.we) begin
                pins.cen = '0;
                pins.a   = req.addr;
            end else if (req.be != '0) begin
                for (int i = 0; i < BANKS; i++) begin
                    pins.cen[i]                  = ~req.be[i];
                    pins.gwen[i]                 = ~req.be[i];
                    pins.wen[i*BANK_W +: BANK_W] = {BANK_W{~req.be[i]}};
                end
                pins.a = req.addr;
                pins.d = req.wdata;
            end
        end
    end

    assign sram_cen  = pins.cen;
    assign sram_gwen = pins.gwen;
    assign sram_wen  = pins.wen;
    assign sram_a    = pins.a;
    assign sram_d    = pins.d;

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_inflight),
        .wdata (sram_q),
        .pop   (pop),
        .rdata (rsp_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The credit rule must never let a read land in a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(rd_inflight && fifo_full && !pop));
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed plus randomized bench for sram_bridge with a behavioural pair of
// 512x8 macros and a word-level reference memory feeding an expected queue.
module tb_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic [1:0]  sram_cen;
    logic [1:0]  sram_gwen;
    logic [15:0] sram_wen;
    logic [8:0]  sram_a;
    logic [15:0] sram_d;
    logic [15:0] sram_q;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] ref_mem [512];
    logic [15:0] exp_q [$];

    logic [7:0]  macro_mem [2][512];
    logic [15:0] macro_q;

    sram_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural macros ----------------
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!sram_cen[i]) begin
                if (!sram_gwen[i]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (!sram_wen[i*8+b]) macro_mem[i][sram_a][b] <= sram_d[i*8+b];
                    end
                end else begin
                    macro_q[i*8 +: 8] <= macro_mem[i][sram_a];
                end
            end
        end
    end
    assign sram_q = macro_q;

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: writes merge enabled bytes into a word memory, reads queue
    // the word as it stands at acceptance.
    task automatic model_accept(input logic we, input logic [8:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be);
        if (we) begin
            if (be[0]) ref_mem[addr][7:0]  = wdata[7:0];
            if (be[1]) ref_mem[addr][15:8] = wdata[15:8];
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                             input logic [1:0] be, input logic rdy, output logic acc);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = rdy;
        #1;
        acc = req_ready;
        if (acc) model_accept(we, addr, wdata, be);
    endtask

    task automatic send_req(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                            input logic [1:0] be, input logic rdy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 32) begin
            drive_req(we, addr, wdata, be, rdy, acc);
            tries++;
        end
        check("send_accept", acc, 1);
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = rdy;
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        #1;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL rsp_extra: observed response %0h expected none", rsp_rdata);
            end
            if (exp_q.size() != 0) check("rsp_data", rsp_rdata, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic        acc;
        logic        we;
        logic        rdy;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  be;

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'h1A5;
        req_wdata = 16'h5555;
        req_be    = 2'b11;
        rsp_ready = 1'b0;

        // Reset holds the bridge closed and the macros idle.
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_cen", sram_cen, 2'b11);
        check("rst_gwen", sram_gwen, 2'b11);
        check("rst_wen", sram_wen, 16'hFFFF);
        check("rst_a", sram_a, 0);
        check("rst_d", sram_d, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);

        // Full-word write then read with latency checks.
        drive_req(1'b1, 9'h1A5, 16'hBEEF, 2'b11, 1'b0, acc);
        check("wr_accept", acc, 1);
        check("wr_cen", sram_cen, 2'b00);
        check("wr_gwen", sram_gwen, 2'b00);
        check("wr_wen", sram_wen, 16'h0000);
        check("wr_d", sram_d, 16'hBEEF);
        drive_req(1'b0, 9'h1A5, 16'h0000, 2'b00, 1'b0, acc);
        check("rd_accept", acc, 1);
        check("rd_cen", sram_cen, 2'b00);
        check("rd_gwen", sram_gwen, 2'b11);
        check("rd_wen", sram_wen, 16'hFFFF);
        check("rd_a", sram_a, 9'h1A5);
        idle(1'b0);
        check("lat_edge1_valid", rsp_valid, 0);
        idle(1'b0);
        check("lat_edge2_valid", rsp_valid, 1);
        check("lat_rdata", rsp_rdata, 16'hBEEF);
        idle(1'b1);
        idle(1'b1);
        check("beef_drained", rsp_valid, 0);

        // Byte lanes, empty byte enable, and read-after-write.
        send_req(1'b1, 9'h042, 16'h1234, 2'b11, 1'b0);
        drive_req(1'b1, 9'h042, 16'hAB00, 2'b10, 1'b0, acc);
        check("bl_accept", acc, 1);
        check("bl_cen", sram_cen, 2'b01);
        check("bl_gwen", sram_gwen, 2'b01);
        check("bl_wen", sram_wen, 16'h00FF);
        drive_req(1'b1, 9'h042, 16'hFFFF, 2'b00, 1'b0, acc);
        check("be0_accept", acc, 1);
        check("be0_cen", sram_cen, 2'b11);
        check("be0_wen", sram_wen, 16'hFFFF);
        check("be0_a", sram_a, 0);
        drive_req(1'b0, 9'h042, 16'h0000, 2'b00, 1'b0, acc);
        check("bl_rd_accept", acc, 1);
        idle(1'b0);
        idle(1'b0);
        check("bl_rdata", rsp_rdata, 16'hAB34);
        idle(1'b1);
        idle(1'b1);

        // Preload every word; 0..3 hold their own index.
        for (int a = 0; a < 512; a++) begin
            wdata = (a < 4) ? 16'(a) : 16'($urandom);
            send_req(1'b1, 9'(a), wdata, 2'b11, 1'b1);
        end

        // Backpressure: only two reads fit while the consumer stalls.
        idle(1'b0);
        for (int a = 0; a < 4; a++) begin
            drive_req(1'b0, 9'(a), 16'h0000, 2'b00, 1'b0, acc);
            check("bp_accept", acc, (a < 2) ? 1 : 0);
        end
        idle(1'b0);
        check("bp_ready_low", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        send_req(1'b0, 9'd2, 16'h0000, 2'b00, 1'b1);
        send_req(1'b0, 9'd3, 16'h0000, 2'b00, 1'b1);
        repeat (4) idle(1'b1);
        check("bp_drained", 32'(exp_q.size()), 0);

        // Streaming reads over the whole array at full rate.
        for (int a = 0; a < 512; a++) begin
            drive_req(1'b0, 9'(a), 16'h0000, 2'b00, 1'b1, acc);
            check("stream_ready", acc, 1);
        end
        repeat (4) idle(1'b1);
        check("stream_drained", 32'(exp_q.size()), 0);

        // Random mixed traffic with random consumer stalls.
        for (int n = 0; n < 400; n++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 9'($urandom_range(0, 511));
            wdata = 16'($urandom);
            be    = 2'($urandom_range(0, 3));
            rdy   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                idle(rdy);
            end else begin
                drive_req(we, addr, wdata, be, rdy, acc);
                if (!acc) send_req(we, addr, wdata, be, 1'b1);
            end
        end
        repeat (6) idle(1'b1);
        check("rand_drained", 32'(exp_q.size()), 0);

        // Reset in the in-flight cycle drops the read.
        drive_req(1'b0, 9'h005, 16'h0000, 2'b00, 1'b1, acc);
        check("rstfl_accept", acc, 1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        exp_q.delete();
        #1;
        check("rstfl_ready_low", req_ready, 0);
        check("rstfl_cen", sram_cen, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstfl_ready", req_ready, 1);
        check("rstfl_valid", rsp_valid, 0);
        repeat (4) begin
            idle(1'b1);
            check("rstfl_no_rsp", rsp_valid, 0);
        end
        // An empty FIFO after reset admits exactly two stalled reads.
        drive_req(1'b0, 9'h007, 16'h0000, 2'b00, 1'b0, acc);
        check("rstfl_cnt_acc0", acc, 1);
        drive_req(1'b0, 9'h008, 16'h0000, 2'b00, 1'b0, acc);
        check("rstfl_cnt_acc1", acc, 1);
        drive_req(1'b0, 9'h009, 16'h0000, 2'b00, 1'b0, acc);
        check("rstfl_cnt_acc2", acc, 0);
        repeat (4) idle(1'b1);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bridge.md
# sram_bridge

Valid/ready request bridge in front of the two gf180mcu 512x8 SRAM macros, presenting them as one 512x16 memory with byte-lane write enables. It sits directly upstream of the macros. It converts word requests into the macros' active-low CEN/GWEN/WEN pin protocol, tracks the one-cycle read latency, and buffers read data in a 2-entry response FIFO so the consumer can apply backpressure without losing data.

## Interface
- ADDR_W, 9, word address width; equals macro depth of 512.
- DATA_W, 16, word width; two 8-bit banks, bank 0 = bits [7:0].
- RSP_DEPTH, 2, response FIFO entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready at rising edge
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  2  byte enables for writes; ignored for reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  DATA_W  read data, in request order
- sram_cen  out  2  per-bank chip enable, active-low
- sram_gwen  out  2  per-bank global write enable, active-low
- sram_wen  out  16  per-bit write enable, active-low; [7:0] bank 0
- sram_a  out  ADDR_W  shared macro address
- sram_d  out  DATA_W  shared macro write data
- sram_q  in  DATA_W  macro read data; [7:0] from bank 0

## Operation
- Macro pins are driven combinationally from the request in the handshake cycle. The macros sample on the same edge that completes the handshake.
- Idle pins (no handshake, or rst_n low): cen=2'b11, gwen=2'b11, wen=16'hFFFF, a=0, d=0.
- Read accept: cen=2'b00, gwen=2'b11, wen=16'hFFFF, a=req_addr. This sets rd_inflight for the next cycle.
- Write accept: bank i has cen[i]=~be[i], gwen[i]=~be[i], and its wen byte = {8{~be[i]}}; a=req_addr, d=req_wdata. Writes produce no response.
- Write with be=2'b00 is accepted and consumed, with no macro access (pins idle).
- rd_inflight cycle: sram_q is valid and is pushed into the response FIFO at the next edge. No other source writes the FIFO.
- req_ready = rst_n && (count + rd_inflight - pop) < RSP_DEPTH, where pop = rsp_valid && rsp_ready.
  - This is a combinational path from rsp_ready to req_ready, and it is intentional.
  - The same condition gates writes, which keeps req_ready independent of req_we.
- rsp_valid = (count != 0). rsp_rdata = FIFO head.
- FIFO push and pop in the same cycle: count is unchanged and order is preserved.
- The credit rule guarantees the FIFO never overflows. An assertion must check that no push happens while full without a simultaneous pop.
- Pointers are 1 bit wide and wrap modulo RSP_DEPTH.

## Timing
- Reset (edge with rst_n=0): count=0, pointers=0, rd_inflight=0.
  - rsp_valid=0 from the following cycle.
  - req_ready=0 and pins idle combinationally while rst_n=0.
- Reset during an in-flight read drops that read. A sram_q value in the cycle after reset is discarded.
- Read latency: handshake at edge N, macro read at N, FIFO push at N+1, rsp_valid high in the cycle after N+1. The response is available 2 edges after accept.
- Throughput: 1 request per cycle sustained with rsp_ready held high.
- With rsp_ready low, at most 2 reads are outstanding (FIFO + inflight). req_ready drops until a pop occurs.
- Read-after-write to the same address on consecutive cycles returns the new data. The macro write completes at its edge.

## Structure
- Package sram_bridge_pkg:
  - BANKS=2, BANK_W=8, SRAM_DEPTH=512.
  - typedef sram_req_t {we, addr, wdata, be}.
  - typedef sram_pins_t {cen, gwen, wen, a, d}.
  - Function idle_pins() returning the idle pin set.
- Sub-module sram_rsp_fifo: parameterised depth and width, with push, pop, full, empty and count. It is also reused later by other memory-manager stages.
- At top level, chip_core replaces its tied-off macro pins with sram_bridge outputs.

## Test plan
- Reset with req_valid=1 -> req_ready=0, cen=2'b11, wen=16'hFFFF. After release: req_ready=1, rsp_valid=0.
- Write addr 9'h1A5 data 16'hBEEF be=2'b11, then read 9'h1A5 -> rsp_rdata=16'hBEEF, with rsp_valid high 2 edges after the read accept.
- Byte-lane write: 16'h1234 be=2'b11, then 16'hAB00 be=2'b10 -> read returns 16'hAB34. In the be=2'b10 cycle: cen=2'b01, wen=16'h00FF.
- Backpressure: rsp_ready=0 with 4 back-to-back reads (addr 0..3 preloaded 16'h0000..0003) -> exactly 2 accepted, then req_ready=0. Raising rsp_ready drains responses in order 0,1,2,3 with no loss or duplication.
- Streaming: 512 consecutive reads with rsp_ready=1 -> req_ready never low after the first cycle, and all responses match preloaded data in order.
- Reset asserted in the rd_inflight cycle -> no rsp_valid pulse afterwards, and count=0.
